// File: rtl/aes_key_expander.sv
// ---------------------------------------------------------------------------
// aes_key_expander
//
// Iterative AES-128 key-expansion engine. One 128-bit cipher key is accepted
// in IDLE. It is emitted as round key 0, and round keys 1..10 are then derived
// one at a time. Each round key is offered on a valid/ready stream together
// with its round index and the Rcon byte used to derive it.
//
// Build option:
//   AES_KEY_EXP_FAST_SUB_EN - when defined, SubWord uses four S-box lookups in
//   parallel, so the SUB phase lasts one cycle. When undefined, one shared
//   S-box is visited once per byte over four cycles. Output values are
//   identical in both builds; only the timing differs.
//
// Ports:
//   clock      in   1    sole clock, rising edge
//   reset      in   1    synchronous, active-high
//   in         in   128  cipher key, in[127:120] = key byte 0, w0 = in[127:96]
//   load       in   1    key valid, accepted when load && in_ready
//   in_ready   out  1    high only in IDLE
//   rk_out     out  128  current round key, same byte order as in
//   rk_valid   out  1    rk_out / round_idx / Rcon_out are valid
//   rk_ready   in   1    downstream accepts, transfer on rk_valid && rk_ready
//   round_idx  out  4    index of the round key on rk_out (0..10)
//   Rcon_out   out  8    Rcon used to derive rk_out (0x00 for round 0)
//   empty      out  1    no expansion in progress (IDLE)
// ---------------------------------------------------------------------------
module aes_key_expander (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] in,
    input  logic         load,
    output logic         in_ready,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   round_idx,
    output logic [7:0]   Rcon_out,
    output logic         empty
);

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset (255 - x) * 8, and 255 - x == ~x for a byte.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2,
        MIX  = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [31:0] w0_reg;
    logic [31:0] w1_reg;
    logic [31:0] w2_reg;
    logic [31:0] w3_reg;
    logic [31:0] temp_reg;
    logic [3:0]  round_reg;
    logic [7:0]  rcon_reg;
    logic [7:0]  rcon_out_reg;
`ifndef AES_KEY_EXP_FAST_SUB_EN
    logic [1:0]  b_reg;
`endif

    // RotWord(w3): byte gi of the rotated word, byte 0 most significant.
    logic [31:0] rot_word;
    logic [7:0]  rot_byte [4];

    assign rot_word = {w3_reg[23:0], w3_reg[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_byte[gi] = rot_word[31-8*gi -: 8];
        end
    endgenerate

`ifdef AES_KEY_EXP_FAST_SUB_EN
    // Four parallel lookups build the whole SubWord in one cycle.
    logic [31:0] sub_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[31-8*gi -: 8] = sbox(rot_byte[gi]);
        end
    endgenerate
`else
    // One shared lookup, fed the byte selected by the sub-byte counter.
    logic [7:0] sbox_out;

    assign sbox_out = sbox(rot_byte[b_reg]);
`endif

    // Next round key, consumed only in MIX.
    logic [31:0] w0_mix;
    logic [31:0] w1_mix;
    logic [31:0] w2_mix;
    logic [31:0] w3_mix;
    logic [7:0]  rcon_xtime;

    always_comb begin
        w0_mix     = w0_reg ^ temp_reg ^ {rcon_reg, 24'h000000};
        w1_mix     = w1_reg ^ w0_mix;
        w2_mix     = w2_reg ^ w1_mix;
        w3_mix     = w3_reg ^ w2_mix;
        rcon_xtime = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    state_next = (round_reg == 4'd10) ? IDLE : SUB;
                end
            end
            SUB: begin
`ifdef AES_KEY_EXP_FAST_SUB_EN
                state_next = MIX;
`else
                if (b_reg == 2'd3) begin
                    state_next = MIX;
                end
`endif
            end
            MIX: begin
                state_next = EMIT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            w0_reg       <= 32'h0;
            w1_reg       <= 32'h0;
            w2_reg       <= 32'h0;
            w3_reg       <= 32'h0;
            temp_reg     <= 32'h0;
            round_reg    <= 4'd0;
            rcon_reg     <= 8'h01;
            rcon_out_reg <= 8'h00;
`ifndef AES_KEY_EXP_FAST_SUB_EN
            b_reg        <= 2'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        w0_reg       <= in[127:96];
                        w1_reg       <= in[95:64];
                        w2_reg       <= in[63:32];
                        w3_reg       <= in[31:0];
                        round_reg    <= 4'd0;
                        rcon_reg     <= 8'h01;
                        rcon_out_reg <= 8'h00;
                    end
                end
                EMIT: begin
`ifndef AES_KEY_EXP_FAST_SUB_EN
                    if (rk_ready) begin
                        b_reg <= 2'd0;
                    end
`endif
                end
                SUB: begin
`ifdef AES_KEY_EXP_FAST_SUB_EN
                    temp_reg <= sub_word;
`else
                    for (int i = 0; i < 4; i++) begin
                        if (b_reg == 2'(i)) begin
                            temp_reg[31-8*i -: 8] <= sbox_out;
                        end
                    end
                    b_reg <= b_reg + 2'd1;
`endif
                end
                MIX: begin
                    w0_reg       <= w0_mix;
                    w1_reg       <= w1_mix;
                    w2_reg       <= w2_mix;
                    w3_reg       <= w3_mix;
                    round_reg    <= round_reg + 4'd1;
                    rcon_out_reg <= rcon_reg;
                    rcon_reg     <= rcon_xtime;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only
    // ------------------------------------------------------------------
    assign in_ready  = (state_reg == IDLE);
    assign empty     = (state_reg == IDLE);
    assign rk_valid  = (state_reg == EMIT);
    assign rk_out    = {w0_reg, w1_reg, w2_reg, w3_reg};
    assign round_idx = round_reg;
    assign Rcon_out  = rcon_out_reg;

endmodule

// File: tb/tb_aes_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expander
//
// Scoreboard bench for aes_key_expander. The stimulus process loads keys and
// pushes the expected round keys (value, index, Rcon and the cycle on which
// each should first be valid) into a queue. A separate monitor pops one entry
// on every rk_valid && rk_ready transfer and compares it. The expected round
// keys are the published FIPS-197 schedules for the two keys used.
// ---------------------------------------------------------------------------
module tb_aes_key_expander;

`ifdef AES_KEY_EXP_FAST_SUB_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 6;
`endif

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    localparam logic [127:0] SCHED_A [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    localparam logic [127:0] SCHED_B [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef struct {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic [7:0]   rcon;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [127:0] in;
    logic         load;
    logic         in_ready;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   round_idx;
    logic [7:0]   Rcon_out;
    logic         empty;

    int   cyc;
    int   n_tests;
    int   n_fails;
    exp_t sb [$];

    aes_key_expander dut (
        .clock     (clk),
        .reset     (reset),
        .in        (in),
        .load      (load),
        .in_ready  (in_ready),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_idx (round_idx),
        .Rcon_out  (Rcon_out),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc holds the number of rising edges seen so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: pops and compares on every transfer
    // ------------------------------------------------------------------
    initial begin : monitor
        bit           presenting;
        int           start_cyc;
        logic [127:0] held_key;
        logic [3:0]   held_idx;
        logic [7:0]   held_rcon;
        exp_t         e;
        presenting = 1'b0;
        start_cyc  = 0;
        held_key   = '0;
        held_idx   = '0;
        held_rcon  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                presenting = 1'b0;
            end else if (rk_valid) begin
                if (!presenting) begin
                    presenting = 1'b1;
                    start_cyc  = cyc;
                    held_key   = rk_out;
                    held_idx   = round_idx;
                    held_rcon  = Rcon_out;
                end else begin
                    n_tests++;
                    if (rk_out !== held_key || round_idx !== held_idx || Rcon_out !== held_rcon) begin
                        n_fails++;
                        $display("[TB] FAIL hold_stable: got %h/%0d/%h, required %h/%0d/%h",
                                 rk_out, round_idx, Rcon_out, held_key, held_idx, held_rcon);
                    end
                end
                if (rk_ready) begin
                    presenting = 1'b0;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fails++;
                        $display("[TB] FAIL unexpected_key: got round %0d key %h with no entry expected",
                                 round_idx, rk_out);
                    end else begin
                        e = sb.pop_front();
                        $display("[TB] xfer round %0d key %h rcon %h first valid cycle %0d",
                                 round_idx, rk_out, Rcon_out, start_cyc);
                        n_tests++;
                        if (rk_out !== e.key || round_idx !== e.rnd || Rcon_out !== e.rcon) begin
                            n_fails++;
                            $display("[TB] FAIL round_key: got %h/%0d/%h, required %h/%0d/%h",
                                     rk_out, round_idx, Rcon_out, e.key, e.rnd, e.rcon);
                        end
                        n_tests++;
                        if (start_cyc != e.cyc) begin
                            n_fails++;
                            $display("[TB] FAIL key_timing round %0d: valid from cycle %0d, required %0d",
                                     e.rnd, start_cyc, e.cyc);
                        end
                    end
                end
            end else if (presenting) begin
                presenting = 1'b0;
                n_tests++;
                n_fails++;
                $display("[TB] FAIL valid_dropped: rk_valid fell in cycle %0d without transfer", cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Push rounds 0..last_round of a schedule; rounds >= stall_round are
    // expected stall_cycles later.
    task automatic push_sched(input bit use_b, input int e_cyc, input int last_round,
                              input int stall_round, input int stall_cycles);
        exp_t x;
        for (int n = 0; n <= last_round; n++) begin
            x.key  = use_b ? SCHED_B[n] : SCHED_A[n];
            x.rnd  = 4'(n);
            x.rcon = RCON[n];
            x.cyc  = e_cyc + GAP * n + ((n >= stall_round) ? stall_cycles : 0);
            sb.push_back(x);
        end
    endtask

    // Load a key at the current cycle; returns the accept-edge cycle number.
    task automatic load_key(input logic [127:0] key, output int e_cyc);
        in   = key;
        load = 1'b1;
        step();
        load  = 1'b0;
        e_cyc = cyc;
    endtask

    task automatic wait_round(input int r);
        int k;
        for (k = 0; k < 300; k++) begin
            if (rk_valid && round_idx == 4'(r)) break;
            step();
        end
        if (k == 300) begin
            n_tests++;
            n_fails++;
            $display("[TB] FAIL wait_round_%0d: timed out, required round %0d to appear", r, r);
        end
    endtask

    task automatic wait_idle(input string name, input int req_cyc);
        int k;
        for (k = 0; k < 300; k++) begin
            step();
            if (in_ready) break;
        end
        n_tests++;
        if (!in_ready || cyc != req_cyc) begin
            n_fails++;
            $display("[TB] FAIL %s: in_ready=%0b at cycle %0d, required 1 at cycle %0d",
                     name, in_ready, cyc, req_cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        int e_a;
        int e_b;
        int e_c;
        n_tests  = 0;
        n_fails  = 0;
        reset    = 1'b1;
        load     = 1'b0;
        in       = '0;
        rk_ready = 1'b1;

        // Reset values.
        step();
        step();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_empty", 128'(empty), 128'd1);
        chk("reset_rk_valid", 128'(rk_valid), 128'd0);
        chk("reset_rk_out", rk_out, 128'd0);
        chk("reset_round_idx", 128'(round_idx), 128'd0);
        chk("reset_rcon_out", 128'(Rcon_out), 128'd0);
        reset = 1'b0;
        step();

        // Key A, rk_ready held high: full schedule, nominal timing.
        load_key(KEY_A, e_a);
        push_sched(1'b0, e_a, 10, 11, 0);
        chk("busy_in_ready", 128'(in_ready), 128'd0);
        chk("busy_empty", 128'(empty), 128'd0);
        wait_idle("idle_after_a", e_a + GAP * 10 + 1);

        // Key B loaded on the very cycle in_ready rose; round 3 stalls
        // for 7 cycles and a foreign load is pulsed during round 4.
        load_key(KEY_B, e_b);
        push_sched(1'b1, e_b, 10, 4, 7);
        wait_round(3);
        rk_ready = 1'b0;
        repeat (7) step();
        rk_ready = 1'b1;
        wait_round(4);
        chk("round4_in_ready", 128'(in_ready), 128'd0);
        in   = KEY_A;
        load = 1'b1;
        step();
        step();
        load = 1'b0;
        wait_idle("idle_after_b", e_b + GAP * 10 + 1 + 7);

        // Key A again, reset while deriving round 6; load held with reset.
        load_key(KEY_A, e_c);
        push_sched(1'b0, e_c, 5, 11, 0);
        wait_round(5);
        step();
        reset = 1'b1;
        load  = 1'b1;
        step();
        reset = 1'b0;
        load  = 1'b0;
        chk("abort_rk_valid", 128'(rk_valid), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_empty", 128'(empty), 128'd1);
        chk("abort_rk_out", rk_out, 128'd0);
        chk("abort_round_idx", 128'(round_idx), 128'd0);
        chk("abort_rcon_out", 128'(Rcon_out), 128'd0);
        step();
        chk("after_abort_rk_valid", 128'(rk_valid), 128'd0);
        repeat (20) step();
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES-128 key-expansion engine that sits directly upstream of the round-key queue. It accepts one 128-bit cipher key, emits it as round key 0, then produces round keys 1..10 one at a time. Each round key is presented on a valid/ready stream with its round index and Rcon byte, for the queue to buffer and hand to the cipher rounds. Byte substitution uses one shared FIPS-197 S-box, visited sequentially.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in`  in  128  cipher key; `in[127:120]` is key byte 0; word w0 = `in[127:96]`.
- `load`  in  1  key valid; accepted on an edge where `load && in_ready`.
- `in_ready`  out  1  high only in IDLE.
- `rk_out`  out  128  current round key, same byte order as `in`.
- `rk_valid`  out  1  `rk_out`, `round_idx` and `Rcon_out` are valid.
- `rk_ready`  in  1  downstream accepts; transfer on `rk_valid && rk_ready`.
- `round_idx`  out  4  index of the round key on `rk_out`, 0..10.
- `Rcon_out`  out  8  Rcon used to derive `rk_out`; 0x00 for round 0.
- `empty`  out  1  high when no key expansion is in progress (IDLE).

## Operation
- Registers: w0..w3 (current round key), temp[31:0], round[3:0], rcon[7:0], sub-byte counter b[1:0], state.
- States: IDLE, EMIT, SUB, MIX.
- IDLE → EMIT on accepted load:
  - w ← `in`, round ← 0, rcon ← 0x01.
- EMIT:
  - `rk_valid`=1; hold all outputs stable until `rk_ready`.
  - On transfer with round==10 → IDLE.
  - Otherwise → SUB with b ← 0.
- SUB:
  - temp byte b ← S(RotWord(w3) byte b); RotWord(w3) = {w3[23:0], w3[31:24]}.
  - b increments; after b==3 → MIX.
- MIX, single cycle, then → EMIT:
  - w0' = w0 ^ temp ^ {rcon, 24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - round ← round+1; `Rcon_out` ← rcon; rcon ← xtime(rcon), i.e. shift left 1 and XOR 0x1B when bit 7 was set.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- `load` is ignored when `in_ready`=0; no queuing of a second key.
- `rk_ready` is a don't-care outside EMIT.
- `rk_valid` never drops without a transfer, except on reset.

## Timing
- Reset values (all take effect at the first edge with `reset`=1):
  - state IDLE, `in_ready`=1, `empty`=1, `rk_valid`=0.
  - `rk_out`=0, `round_idx`=0, `Rcon_out`=0x00, internal rcon=0x01.
- `load` is ignored on any edge where `reset`=1.
- Reset mid-expansion aborts immediately. Outputs return to reset values after that edge, and no partial round key is emitted.
- Latency: load accepted at edge E; `rk_valid` with round 0 is seen in the cycle after E.
- Transfer at edge T:
  - SUB occupies cycles T+1..T+4, MIX cycle T+5.
  - Next `rk_valid` visible after edge T+5, i.e. 6 edges between consecutive transfers.
- With `rk_ready` tied high:
  - round key n is valid in cycle 1+6n after E; round 10 in cycle 61.
  - `in_ready` returns high in cycle 62.
- Backpressure: stalls in EMIT only; each stalled cycle adds one cycle to every later round key.
- `in_ready` and `empty` are decoded from the state register, not from `load`.

## Configuration
- `AES_KEY_EXP_FAST_SUB_EN`:
  - Defined: four S-box instances; SUB lasts one cycle, with all four temp bytes written together.
  - Defined: 3 edges between transfers; round 10 valid in cycle 31 with `rk_ready` high.
  - Undefined: single shared S-box, 4-cycle SUB as above.
- Output values are identical in both builds; only timing differs.

## Test plan
- Reset → `in_ready`=1, `empty`=1, `rk_valid`=0, `rk_out`=0. Assert `reset` mid-round 5 → IDLE next edge, `rk_valid`=0.
- Load 000102030405060708090a0b0c0d0e0f, `rk_ready`=1:
  - rk1 = d6aa74fdd2af72fadaa678f1d6ab76fe with `Rcon_out`=01.
  - rk10 = 13111d7fe3944a17f307a78b4d2b30c5 with `Rcon_out`=36, in cycle 61 (31 with FAST_SUB).
- Load 2b7e151628aed2a6abf7158809cf4f3c:
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Hold `rk_ready`=0 for 7 cycles in round 3:
  - `rk_out`, `round_idx`=3 and `Rcon_out`=04 stay stable.
  - All later keys are delayed by exactly 7 cycles.
- Pulse `load` with a different key during round 4 → ignored; remaining keys match the original key's schedule.
- Back-to-back keys: load again on the cycle `in_ready` rises → round 0 of the new key is valid the following cycle.
